// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: shared types and constants for the on-chip JTAG scan sequencer.
// Opcodes match the tap_main instruction decode.
package jtag_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_SEL_DR1,
        ST_SEL_IR,
        ST_CAP_IR,
        ST_ENT_SIR,
        ST_SHIFT_IR,
        ST_UPD_IR,
        ST_SEL_DR2,
        ST_CAP_DR,
        ST_ENT_SDR,
        ST_SHIFT_DR,
        ST_UPD_DR,
        ST_RTI
    } seq_state_t;

    localparam logic [5:0] IR_IDCODE = 6'h01;
    localparam logic [5:0] IR_LED    = 6'h02;
    localparam logic [5:0] IR_BYPASS = 6'h3F;

    // Fixed cycles per scan on top of the IR and DR shift lengths.
    localparam int SEQ_OVERHEAD = 10;
    // Preamble length: five TMS=1 cycles to reach Test-Logic-Reset, one TMS=0 into Run-Test/Idle.
    localparam int PRE_LEN = 6;

endpackage

// File: rtl/jtag_seq_shreg.sv
// jtag_seq_shreg: DR shift register for the scan sequencer.
// Parallel-loads the write data, shifts it out LSB first while TDO enters at the
// top bit, then right-justifies the captured bits into the read-data register.
module jtag_seq_shreg #(
    parameter int DR_MAX = 32,
    parameter int LEN_W  = 6
) (
    input  logic              tck,
    input  logic              trst_n,
    input  logic              load,
    input  logic [DR_MAX-1:0] wdata,
    input  logic              shift,
    input  logic              sin,
    input  logic              justify,
    input  logic [LEN_W-1:0]  shamt,
    output logic              sout_nx,
    output logic [DR_MAX-1:0] pout
);

    logic [DR_MAX-1:0] sr;

    // Serial bit that will be presented after this edge; lets TDI be registered
    // without lagging the shift by a cycle.
    assign sout_nx = load ? wdata[0] : (shift ? sr[1] : sr[0]);

    // Shift register: load write data, then shift right with TDO entering at the MSB.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= wdata;
        end else if (shift) begin
            sr <= {sin, sr[DR_MAX-1:1]};
        end
    end

    // Read data only changes on the justify step; holds otherwise.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            pout <= '0;
        end else if (justify) begin
            pout <= sr >> shamt;
        end
    end

endmodule

// File: rtl/jtag_scan_seq.sv
// jtag_scan_seq: drives tap_main TMS/TDI for one IR load plus one DR scan,
// returning to Run-Test/Idle and handing back the TDO bits in parallel.
// Optional build macro JTAG_SEQ_TLR_PRE_EN: prefix every scan with a
// TLR-then-RTI preamble so the TAP may start from any state.
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_IDLE     | TAP parked in Run-Test/Idle, waiting for start
// ST_PRE      | preamble: TMS=1 x5 then TMS=0 (macro builds only)
// ST_SEL_DR1  | RTI -> Select-DR
// ST_SEL_IR   | Select-DR -> Select-IR
// ST_CAP_IR   | Select-IR -> Capture-IR
// ST_ENT_SIR  | Capture-IR -> Shift-IR
// ST_SHIFT_IR | IR bits out on TDI, TMS=1 on the last bit
// ST_UPD_IR   | Exit1-IR -> Update-IR
// ST_SEL_DR2  | Update-IR -> Select-DR
// ST_CAP_DR   | Select-DR -> Capture-DR
// ST_ENT_SDR  | Capture-DR -> Shift-DR
// ST_SHIFT_DR | DR bits out on TDI, TDO sampled, TMS=1 on the last bit
// ST_UPD_DR   | Exit1-DR -> Update-DR
// ST_RTI      | Update-DR -> RTI, read data right-justified
module jtag_scan_seq
    import jtag_seq_pkg::*;
#(
    parameter int IR_WIDTH = 6,
    parameter int DR_MAX   = 32,
    parameter int LEN_W    = 6
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                start,
    input  logic [IR_WIDTH-1:0] ir_value,
    input  logic [LEN_W-1:0]    dr_len,
    input  logic [DR_MAX-1:0]   dr_wdata,
    input  logic                tdo_i,
    output logic                tms_o,
    output logic                tdi_o,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DR_MAX-1:0]   dr_rdata
);

    localparam int CNT_W = ($clog2(IR_WIDTH) > LEN_W) ? $clog2(IR_WIDTH) : LEN_W;
    localparam logic [CNT_W-1:0] IR_LOAD  = CNT_W'(IR_WIDTH - 1);
    localparam logic [LEN_W-1:0] DR_MAX_L = LEN_W'(DR_MAX);
`ifdef JTAG_SEQ_TLR_PRE_EN
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_LEN - 1);
`endif

    seq_state_t          state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [IR_WIDTH-1:0] ir_sh, ir_sh_nx;
    logic [LEN_W-1:0]    len_q, len_nx;
    logic                awake;
    logic                tms_nx, tdi_nx, ready_nx, busy_nx, done_nx, err_nx;
    logic                sr_load, sr_shift, sr_justify, sr_sout_nx;
    logic                len_ok, accept, reject;

    assign len_ok = (dr_len != '0) && (dr_len <= DR_MAX_L);
    assign accept = ready && start && len_ok;
    assign reject = ready && start && !len_ok;

    // Next-state, counter and shift control; TMS/TDI are derived from the
    // next state so the registered pins line up with the state they belong to.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ir_sh_nx   = ir_sh;
        len_nx     = len_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_justify = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    ir_sh_nx = ir_value;
                    len_nx   = dr_len;
                    sr_load  = 1'b1;
`ifdef JTAG_SEQ_TLR_PRE_EN
                    state_nx = ST_PRE;
                    cnt_nx   = PRE_LOAD;
`else
                    state_nx = ST_SEL_DR1;
`endif
                end else if (reject) begin
                    err_nx = 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt == '0) state_nx = ST_SEL_DR1;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_SEL_DR1: state_nx = ST_SEL_IR;
            ST_SEL_IR:  state_nx = ST_CAP_IR;
            ST_CAP_IR:  state_nx = ST_ENT_SIR;
            ST_ENT_SIR: begin
                state_nx = ST_SHIFT_IR;
                cnt_nx   = IR_LOAD;
            end
            ST_SHIFT_IR: begin
                ir_sh_nx = ir_sh >> 1;
                if (cnt == '0) state_nx = ST_UPD_IR;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_UPD_IR:  state_nx = ST_SEL_DR2;
            ST_SEL_DR2: state_nx = ST_CAP_DR;
            ST_CAP_DR:  state_nx = ST_ENT_SDR;
            ST_ENT_SDR: begin
                state_nx = ST_SHIFT_DR;
                cnt_nx   = CNT_W'(len_q - 1'b1);
            end
            ST_SHIFT_DR: begin
                sr_shift = 1'b1;
                if (cnt == '0) state_nx = ST_UPD_DR;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_UPD_DR: state_nx = ST_RTI;
            ST_RTI: begin
                sr_justify = 1'b1;
                done_nx    = 1'b1;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        case (state_nx)
            ST_SEL_DR1, ST_SEL_IR, ST_UPD_IR, ST_SEL_DR2, ST_UPD_DR: tms_nx = 1'b1;
            ST_SHIFT_IR, ST_SHIFT_DR: tms_nx = (cnt_nx == '0);
            ST_PRE:                   tms_nx = (cnt_nx != '0);
            default:                  tms_nx = 1'b0;
        endcase

        if (state_nx == ST_SHIFT_IR)      tdi_nx = ir_sh_nx[0];
        else if (state_nx == ST_SHIFT_DR) tdi_nx = sr_sout_nx;
        else                              tdi_nx = 1'b0;

        ready_nx = awake && (state_nx == ST_IDLE);
        busy_nx  = (state_nx != ST_IDLE);
    end

    // State and registered outputs; awake holds ready low for the first
    // edge after reset so the TAP sees one TMS=0 cycle into Run-Test/Idle.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ir_sh <= '0;
            len_q <= '0;
            awake <= 1'b0;
            tms_o <= 1'b0;
            tdi_o <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ir_sh <= ir_sh_nx;
            len_q <= len_nx;
            awake <= 1'b1;
            tms_o <= tms_nx;
            tdi_o <= tdi_nx;
            ready <= ready_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

    jtag_seq_shreg #(
        .DR_MAX (DR_MAX),
        .LEN_W  (LEN_W)
    ) u_shreg (
        .tck     (tck),
        .trst_n  (trst_n),
        .load    (sr_load),
        .wdata   (dr_wdata),
        .shift   (sr_shift),
        .sin     (tdo_i),
        .justify (sr_justify),
        .shamt   (DR_MAX_L - len_q),
        .sout_nx (sr_sout_nx),
        .pout    (dr_rdata)
    );

endmodule

// File: tb/tb_jtag_scan_seq.sv
// tb_jtag_scan_seq: drives jtag_scan_seq against a behavioural IEEE 1149.1 TAP
// with IDCODE, LED (8-bit) and 1-bit bypass data registers. Expected read data
// and LED contents come from the bit-stream rule: the TDR shifts out its
// captured bits first, followed by the bits shifted in.
module tb_jtag_scan_seq;
    import jtag_seq_pkg::*;

    localparam int IRW = 6;
    localparam logic [31:0] IDCODE_VAL = 32'hA8B967EE;
`ifdef JTAG_SEQ_TLR_PRE_EN
    localparam int LAT_BASE = 16;
    localparam int PFX_LEN  = 10;
    localparam logic [PFX_LEN-1:0] PFX_EXP = 10'b0011011111;
    localparam int RST_CYC  = 12;
`else
    localparam int LAT_BASE = 10;
    localparam int PFX_LEN  = 4;
    localparam logic [PFX_LEN-1:0] PFX_EXP = 4'b0011;
    localparam int RST_CYC  = 6;
`endif

    localparam int T_TLR = 0, T_RTI = 1, T_SELDR = 2, T_CAPDR = 3, T_SHDR = 4,
                   T_EX1DR = 5, T_PADR = 6, T_EX2DR = 7, T_UPDR = 8, T_SELIR = 9,
                   T_CAPIR = 10, T_SHIR = 11, T_EX1IR = 12, T_PAIR = 13,
                   T_EX2IR = 14, T_UPIR = 15;

    logic        tck = 1'b0;
    logic        trst_n, start;
    logic [5:0]  ir_value, dr_len;
    logic [31:0] dr_wdata;
    logic        tdo_i = 1'b0;
    logic        tms_o, tdi_o, ready, busy, done, err;
    logic [31:0] dr_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // TAP model state
    int          tap_st = T_TLR;
    logic [5:0]  tap_ir = IR_IDCODE;
    logic [5:0]  ir_sr  = '0;
    logic [31:0] dr_sr  = '0;
    int          dr_w   = 1;
    logic [7:0]  led    = 8'hC3;
    logic        tms_s  = 1'b0;
    logic        tdi_s  = 1'b0;

    // Bench-side reference values
    logic [7:0]  led_ref = 8'hC3;
    logic [31:0] last_rdata_ref = '0;

    jtag_scan_seq #(.IR_WIDTH(6), .DR_MAX(32), .LEN_W(6)) dut (
        .tck      (tck),
        .trst_n   (trst_n),
        .start    (start),
        .ir_value (ir_value),
        .dr_len   (dr_len),
        .dr_wdata (dr_wdata),
        .tdo_i    (tdo_i),
        .tms_o    (tms_o),
        .tdi_o    (tdi_o),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dr_rdata (dr_rdata)
    );

    always #5 tck = ~tck;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tap_next(input int st, input logic tms);
        case (st)
            T_TLR:   return tms ? T_TLR   : T_RTI;
            T_RTI:   return tms ? T_SELDR : T_RTI;
            T_SELDR: return tms ? T_SELIR : T_CAPDR;
            T_CAPDR: return tms ? T_EX1DR : T_SHDR;
            T_SHDR:  return tms ? T_EX1DR : T_SHDR;
            T_EX1DR: return tms ? T_UPDR  : T_PADR;
            T_PADR:  return tms ? T_EX2DR : T_PADR;
            T_EX2DR: return tms ? T_UPDR  : T_SHDR;
            T_UPDR:  return tms ? T_SELDR : T_RTI;
            T_SELIR: return tms ? T_TLR   : T_CAPIR;
            T_CAPIR: return tms ? T_EX1IR : T_SHIR;
            T_SHIR:  return tms ? T_EX1IR : T_SHIR;
            T_EX1IR: return tms ? T_UPIR  : T_PAIR;
            T_PAIR:  return tms ? T_EX2IR : T_PAIR;
            T_EX2IR: return tms ? T_UPIR  : T_SHIR;
            default: return tms ? T_SELDR : T_RTI;
        endcase
    endfunction

    function automatic int tdr_width(input logic [5:0] ir);
        if (ir == IR_IDCODE) return 32;
        if (ir == IR_LED)    return 8;
        return 1;
    endfunction

    // Bit i of the stream leaving a w-bit TDR: captured bits, then shifted-in data.
    function automatic logic s_bit(input int i, input int w, input logic [31:0] cap,
                                   input logic [31:0] wd);
        if (i < w) return cap[i];
        if (i - w < 32) return wd[i - w];
        return 1'b0;
    endfunction

    // Pin sampling away from the rising edge feeds the TAP model.
    always @(negedge tck) begin
        tms_s <= tms_o;
        tdi_s <= tdi_o;
    end

    // TAP presents TDO on the falling edge.
    always @(negedge tck) begin
        if (tap_st == T_SHDR)      tdo_i = dr_sr[0];
        else if (tap_st == T_SHIR) tdo_i = ir_sr[0];
        else                       tdo_i = 1'b0;
    end

    // Behavioural TAP controller plus its instruction and data registers.
    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st <= T_TLR;
            tap_ir <= IR_IDCODE;
        end else begin
            case (tap_st)
                T_TLR:   tap_ir <= IR_IDCODE;
                T_CAPIR: ir_sr <= 6'b000001;
                T_SHIR:  ir_sr <= {tdi_s, ir_sr[5:1]};
                T_UPIR:  tap_ir <= ir_sr;
                T_CAPDR: begin
                    dr_w <= tdr_width(tap_ir);
                    if (tap_ir == IR_IDCODE)   dr_sr <= IDCODE_VAL;
                    else if (tap_ir == IR_LED) dr_sr <= {24'h0, led};
                    else                       dr_sr <= '0;
                end
                T_SHDR:  dr_sr <= (dr_sr >> 1) | ({31'h0, tdi_s} << (dr_w - 1));
                T_UPDR:  if (tap_ir == IR_LED) led <= dr_sr[7:0];
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms_s);
        end
    end

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 8 && !ready; i++) @(negedge tck);
        check_val({tag, " ready_wait"}, ready, 1'b1);
    endtask

    task automatic run_scan(input logic [5:0] ir, input logic [5:0] len,
                            input logic [31:0] wd, input bit poke, input string tag);
        int lat, cyc, w;
        logic [31:0] cap, expd;
        logic [7:0]  led_new;
        logic [PFX_LEN-1:0] pfx;
        bit busy_bad;

        wait_ready(tag);
        w   = tdr_width(ir);
        cap = (ir == IR_IDCODE) ? IDCODE_VAL : (ir == IR_LED) ? {24'h0, led_ref} : 32'h0;
        expd = '0;
        for (int k = 0; k < int'(len); k++) expd[k] = s_bit(k, w, cap, wd);
        led_new = led_ref;
        if (ir == IR_LED)
            for (int j = 0; j < 8; j++) led_new[j] = s_bit(int'(len) + j, w, cap, wd);
        lat = LAT_BASE + IRW + int'(len);

        ir_value = ir; dr_len = len; dr_wdata = wd; start = 1'b1;
        @(negedge tck);
        start = 1'b0;
        ir_value = 6'($urandom); dr_len = 6'($urandom); dr_wdata = $urandom;
        cyc = 0; busy_bad = 1'b0; pfx = '0;
        check_val({tag, " accept"}, {ready, busy}, 2'b01);
        while (!done && cyc < lat + 20) begin
            if (cyc < PFX_LEN) pfx[cyc] = tms_o;
            if (!busy) busy_bad = 1'b1;
            if (poke && cyc == lat - 3) start = 1'b1;
            @(negedge tck);
            cyc++;
            start = 1'b0;
        end
        check_val({tag, " latency"}, cyc, lat);
        check_val({tag, " done"}, done, 1'b1);
        check_val({tag, " idle_flags"}, {ready, busy, err}, 3'b100);
        check_val({tag, " busy_held"}, busy_bad, 1'b0);
        check_val({tag, " tms_prefix"}, pfx, PFX_EXP);
        check_val({tag, " dr_rdata"}, dr_rdata, expd);
        check_val({tag, " tap_rti"}, tap_st, T_RTI);
        check_val({tag, " tap_ir"}, tap_ir, ir);
        check_val({tag, " led"}, led, led_new);
        led_ref = led_new;
        last_rdata_ref = expd;
        @(negedge tck);
        check_val({tag, " done_pulse"}, done, 1'b0);
    endtask

    task automatic bad_start(input logic [5:0] len, input string tag);
        wait_ready(tag);
        ir_value = IR_LED; dr_len = len; dr_wdata = $urandom; start = 1'b1;
        @(negedge tck);
        start = 1'b0;
        check_val({tag, " err_pulse"}, {err, busy, tms_o, ready}, 4'b1001);
        @(negedge tck);
        check_val({tag, " err_clear"}, {err, busy, tms_o, ready}, 4'b0001);
        check_val({tag, " rdata_held"}, dr_rdata, last_rdata_ref);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        trst_n = 1'b0; start = 1'b0; ir_value = '0; dr_len = '0; dr_wdata = '0;
        #3;
        check_val("rst_pins", {tms_o, tdi_o}, 2'b00);
        check_val("rst_flags", {ready, busy, done, err}, 4'b0000);
        check_val("rst_rdata", dr_rdata, 32'h0);

        @(negedge tck); @(negedge tck);
        trst_n = 1'b1;
        ir_value = IR_LED; dr_len = 6'd8; dr_wdata = 32'hFF; start = 1'b1;
        @(negedge tck);
        check_val("ready_edge1", ready, 1'b0);
        check_val("early_start_ignored", busy, 1'b0);
        start = 1'b0;
        @(negedge tck);
        check_val("ready_edge2", ready, 1'b1);
        check_val("early_start_no_scan", {busy, tms_o}, 2'b00);

        run_scan(IR_IDCODE, 6'd32, 32'h0, 1'b0, "idcode");
        run_scan(IR_LED, 6'd8, 32'h5A, 1'b0, "led");
        bad_start(6'd0, "len0");
        bad_start(6'd33, "len33");
        run_scan(IR_LED, 6'd8, 32'h3C, 1'b1, "poke_busy");

        // Abort a scan while the IR is being shifted.
        wait_ready("abort");
        ir_value = IR_LED; dr_len = 6'd16; dr_wdata = $urandom; start = 1'b1;
        @(negedge tck);
        start = 1'b0;
        repeat (RST_CYC) @(negedge tck);
        check_val("abort_in_shift", {busy, tap_st == T_SHIR}, 2'b11);
        #2 trst_n = 1'b0;
        #1;
        check_val("abort_pins", {tms_o, tdi_o}, 2'b00);
        check_val("abort_flags", {ready, busy, done, err}, 4'b0000);
        check_val("abort_rdata", dr_rdata, 32'h0);
        last_rdata_ref = '0;
        @(negedge tck);
        trst_n = 1'b1;
        @(negedge tck);
        check_val("abort_ready_edge1", ready, 1'b0);
        @(negedge tck);
        check_val("abort_ready_edge2", ready, 1'b1);
        run_scan(IR_IDCODE, 6'd32, $urandom, 1'b0, "post_abort");

        for (int n = 0; n < 24; n++) begin
            logic [5:0] ir;
            case ($urandom_range(0, 3))
                0:       ir = IR_IDCODE;
                1:       ir = IR_LED;
                2:       ir = IR_BYPASS;
                default: ir = 6'($urandom);
            endcase
            run_scan(ir, 6'($urandom_range(1, 32)), $urandom, 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
